// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with post-reset clear sequencer
// and per-register busy scoreboard for decode hazard stalls.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   ready         high once every register has been cleared
//   rd_valid/addr NUM_RD packed read ports -> rd_data, rd_busy
//   wr_en/addr/data  single posedge write port (x0 discarded)
//   alloc_en/addr mark a register as awaiting a producer
//   flush         clear every busy bit
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int NUM_RD = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NUM_RD-1:0]        rd_valid,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     flush
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  busy, busy_nxt;
  logic              wr_ok;
  logic              alloc_ok;
  logic [ADDR_W-1:0] ra;
  logic              fwd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    ready       = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + ADDR_W'(1);
        if (clr_ptr == LAST) begin
          state_nxt   = READY;
          clr_ptr_nxt = '0;
        end
      end
      READY: begin
        ready = 1'b1;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  assign wr_ok    = ready && wr_en && (wr_addr != '0);
  assign alloc_ok = ready && alloc_en && (alloc_addr != '0);

  // Array is not reset: the sequencer zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!ready) begin
      regs[clr_ptr] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Alloc applied after write-clear so a new producer wins a tie.
  always_comb begin
    busy_nxt = busy;
    if (ready) begin
      if (flush) begin
        busy_nxt = '0;
      end else begin
        if (wr_ok)    busy_nxt[wr_addr]    = 1'b0;
        if (alloc_ok) busy_nxt[alloc_addr] = 1'b1;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    fwd     = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra  = rd_addr[i*ADDR_W +: ADDR_W];
      fwd = BYPASS && wr_ok && (wr_addr == ra);
      if (ready && rd_valid[i] && (ra != '0)) begin
        rd_data[i*XLEN +: XLEN] = fwd ? wr_data : regs[ra];
        rd_busy[i]              = busy[ra] && !fwd;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: vector table + scoreboard bench for regfile_sb,
// one instance with bypass and one without, sharing stimulus.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rd_valid;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        flush;

  logic        ready_b, ready_n;
  logic [63:0] data_b, data_n;
  logic [1:0]  busy_b, busy_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .ready(ready_b),
    .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_data(data_b), .rd_busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .flush(flush)
  );

  regfile_sb #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .ready(ready_n),
    .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_data(data_n), .rd_busy(busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .flush(flush)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ae;
    logic [4:0]  aa;
    logic        fl;
    logic [1:0]  rv;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [1:0]  nb;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] d0, d1, n0, n1;
    logic [1:0]  b, nb;
  } exp_t;

  vec_t vt[$];
  exp_t exp_q[$];

  function automatic vec_t v(
    logic we, logic [4:0] wa, logic [31:0] wd,
    logic ae, logic [4:0] aa, logic fl,
    logic [1:0] rv, logic [4:0] a0, logic [4:0] a1,
    logic [31:0] d0, logic [31:0] d1, logic [1:0] b,
    logic [31:0] n0, logic [31:0] n1, logic [1:0] nb);
    vec_t r;
    r.we = we; r.wa = wa; r.wd = wd;
    r.ae = ae; r.aa = aa; r.fl = fl;
    r.rv = rv; r.a0 = a0; r.a1 = a1;
    r.d0 = d0; r.d1 = d1; r.b = b;
    r.n0 = n0; r.n1 = n1; r.nb = nb;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ae,
                       input logic [4:0] aa, input logic fl,
                       input logic [1:0] rv, input logic [4:0] a0,
                       input logic [4:0] a1);
    wr_en = we; wr_addr = wa; wr_data = wd;
    alloc_en = ae; alloc_addr = aa; flush = fl;
    rd_valid = rv; rd_addr = {a1, a0};
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  // Counts posedges after rst release until each ready rises.
  task automatic count_ready(input bit pulse, output int nb,
                             output int nn);
    nb = 0;
    nn = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (pulse && k >= 20 && k <= 22)
        drive(1, 5'd2, 32'hFFFF, 1, 5'd2, k == 22,
              2'b11, 5'd2, 5'd31);
      else if (pulse && k == 23)
        drive(1, 5'd31, 32'h1, 1, 5'd31, 0, 2'b11, 5'd2, 5'd31);
      else
        idle();
      if (ready_b && nb == 0) nb = k;
      if (ready_n && nn == 0) nn = k;
    end
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] d0,
                        input logic [31:0] d1);
    chk({nm, "_b_d0"}, data_b[31:0], d0);
    chk({nm, "_b_d1"}, data_b[63:32], d1);
    chk({nm, "_n_d0"}, data_n[31:0], d0);
    chk({nm, "_n_d1"}, data_n[63:32], d1);
    chk({nm, "_b_busy"}, 32'(busy_b), 32'd0);
    chk({nm, "_n_busy"}, 32'(busy_n), 32'd0);
  endtask

  initial begin
    int   nb, nn;
    exp_t e;

    idle();
    #3 rst = 1'b0;
    rd_valid = 2'b11;
    rd_addr  = {5'd31, 5'd5};
    #10;
    chk("rst_ready_b", 32'(ready_b), 32'd0);
    chk("rst_ready_n", 32'(ready_n), 32'd0);
    chk_rd("rst_read", 32'd0, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    count_ready(1'b0, nb, nn);
    chk("ready_cycles_b", nb, 32);
    chk("ready_cycles_n", nn, 32);

    for (int a = 0; a < 32; a++) begin
      @(posedge clk);
      #1 drive(0, 0, 0, 0, 0, 0, 2'b11, 5'(a), 5'(31 - a));
      @(negedge clk);
      chk_rd($sformatf("zero_x%0d", a), 32'd0, 32'd0);
    end

    //    we wa  wd            ae aa fl rv     a0 a1 d0 d1 b n0 n1 nb
    vt.push_back(v(1, 5, 32'hDEADBEEF, 0, 0, 0, 2'b11, 5, 0,
                   32'hDEADBEEF, 0, 2'b00, 0, 0, 2'b00));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 2'b11, 5, 0,
                   32'hDEADBEEF, 0, 2'b00, 32'hDEADBEEF, 0, 2'b00));
    vt.push_back(v(1, 0, 32'h1234, 0, 0, 0, 2'b11, 0, 5,
                   0, 32'hDEADBEEF, 2'b00, 0, 32'hDEADBEEF, 2'b00));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 2'b11, 0, 0,
                   0, 0, 2'b00, 0, 0, 2'b00));
    vt.push_back(v(1, 7, 32'hA5A5A5A5, 0, 0, 0, 2'b11, 7, 7,
                   32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 0, 0, 2'b00));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 2'b11, 7, 5,
                   32'hA5A5A5A5, 32'hDEADBEEF, 2'b00,
                   32'hA5A5A5A5, 32'hDEADBEEF, 2'b00));
    vt.push_back(v(0, 0, 0, 1, 3, 0, 2'b11, 3, 3,
                   0, 0, 2'b00, 0, 0, 2'b00));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 2'b01, 3, 3,
                   0, 0, 2'b01, 0, 0, 2'b01));
    vt.push_back(v(1, 3, 32'h11, 0, 0, 0, 2'b11, 3, 3,
                   32'h11, 32'h11, 2'b00, 0, 0, 2'b11));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 2'b11, 3, 3,
                   32'h11, 32'h11, 2'b00, 32'h11, 32'h11, 2'b00));
    vt.push_back(v(1, 3, 32'h22, 1, 3, 0, 2'b11, 3, 5,
                   32'h22, 32'hDEADBEEF, 2'b00,
                   32'h11, 32'hDEADBEEF, 2'b00));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 2'b11, 3, 3,
                   32'h22, 32'h22, 2'b11, 32'h22, 32'h22, 2'b11));
    vt.push_back(v(0, 0, 0, 1, 1, 0, 2'b11, 1, 2,
                   0, 0, 2'b00, 0, 0, 2'b00));
    vt.push_back(v(0, 0, 0, 1, 2, 0, 2'b11, 1, 2,
                   0, 0, 2'b01, 0, 0, 2'b01));
    vt.push_back(v(0, 0, 0, 1, 4, 0, 2'b11, 1, 2,
                   0, 0, 2'b11, 0, 0, 2'b11));
    vt.push_back(v(0, 0, 0, 1, 6, 1, 2'b11, 4, 6,
                   0, 0, 2'b01, 0, 0, 2'b01));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 2'b11, 1, 6,
                   0, 0, 2'b00, 0, 0, 2'b00));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 2'b11, 3, 4,
                   32'h22, 0, 2'b00, 32'h22, 0, 2'b00));
    vt.push_back(v(1, 9, 32'h99, 1, 8, 0, 2'b11, 8, 9,
                   0, 32'h99, 2'b00, 0, 0, 2'b00));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 2'b11, 8, 9,
                   0, 32'h99, 2'b01, 0, 32'h99, 2'b01));
    vt.push_back(v(0, 0, 0, 1, 0, 0, 2'b11, 0, 0,
                   0, 0, 2'b00, 0, 0, 2'b00));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 2'b11, 0, 8,
                   0, 0, 2'b10, 0, 0, 2'b10));
    vt.push_back(v(1, 8, 32'h5, 0, 0, 1, 2'b11, 8, 8,
                   32'h5, 32'h5, 2'b00, 0, 0, 2'b11));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 2'b11, 8, 8,
                   32'h5, 32'h5, 2'b00, 32'h5, 32'h5, 2'b00));
    vt.push_back(v(1, 31, 32'hCAFEF00D, 0, 0, 0, 2'b10, 31, 31,
                   0, 32'hCAFEF00D, 2'b00, 0, 0, 2'b00));
    vt.push_back(v(0, 0, 0, 0, 0, 0, 2'b11, 31, 9,
                   32'hCAFEF00D, 32'h99, 2'b00,
                   32'hCAFEF00D, 32'h99, 2'b00));

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].ae, vt[i].aa,
            vt[i].fl, vt[i].rv, vt[i].a0, vt[i].a1);
      e.idx = i;
      e.d0 = vt[i].d0; e.d1 = vt[i].d1; e.b = vt[i].b;
      e.n0 = vt[i].n0; e.n1 = vt[i].n1; e.nb = vt[i].nb;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_b_d0", e.idx), data_b[31:0], e.d0);
      chk($sformatf("v%0d_b_d1", e.idx), data_b[63:32], e.d1);
      chk($sformatf("v%0d_b_busy", e.idx), 32'(busy_b), 32'(e.b));
      chk($sformatf("v%0d_n_d0", e.idx), data_n[31:0], e.n0);
      chk($sformatf("v%0d_n_d1", e.idx), data_n[63:32], e.n1);
      chk($sformatf("v%0d_n_busy", e.idx), 32'(busy_n), 32'(e.nb));
    end

    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 2'b11, 5'd31, 5'd9);
    rst = 1'b0;
    #2;
    chk("rst2_ready_b", 32'(ready_b), 32'd0);
    chk_rd("rst2_read", 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_ready_b", 32'(ready_b), 32'd0);
    rst = 1'b1;
    count_ready(1'b1, nb, nn);
    chk("mid_cycles_b", nb, 32);
    chk("mid_cycles_n", nn, 32);

    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 2'b11, 5'd2, 5'd31);
    @(negedge clk);
    chk_rd("post_clr_a", 32'd0, 32'd0);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 2'b11, 5'd5, 5'd9);
    @(negedge clk);
    chk_rd("post_clr_b", 32'd0, 32'd0);

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
